param_cache: RTL and testbench

PARAM_CACHE -- requirements
Module: param_cache

---
 rtl/param_cache.sv | 269 ++++++++++++++++++++++++++
 tb/tb_param_cache.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_cache.sv
// param_cache: parameterised set-associative write-through data cache.
//   Read hits return in the same cycle. Read and write misses allocate the line
//   and fill it word by word from memory. Every write is also sent to memory,
//   one word at a time, after its byte lanes are merged into the cached word.
// Ports:
//   i_clk, i_rst     clock; synchronous active-high reset
//   o_mem_*, i_mem_* memory side: byte-addressed word reads and writes,
//                    held until i_mem_ready; read data returns in order on i_mem_valid
//   i_req_*, o_busy  CPU side: one request at a time; o_busy=1 stalls it
//   o_res_rdata      read data with unselected byte lanes zeroed
//   i_flush          invalidates every line (IDLE only)
//   o_hit_count, o_miss_count  lookup statistics, wrap modulo 2**32
module param_cache #(
  parameter int unsigned OFFSET_BITS = 4,
  parameter int unsigned SET_BITS    = 5,
  parameter int unsigned WAYS        = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid,
  output logic        o_busy,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [3:0]  i_req_mask,
  input  logic [31:0] i_req_wdata,
  output logic [31:0] o_res_rdata,
  input  logic        i_flush,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count
);

  localparam int unsigned WORDS  = 1 << (OFFSET_BITS - 2);
  localparam int unsigned WORD_W = OFFSET_BITS - 2;
  localparam int unsigned SETS   = 1 << SET_BITS;
  localparam int unsigned TAG_LO = OFFSET_BITS + SET_BITS;
  localparam int unsigned TAG_W  = 32 - TAG_LO;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t state_q, state_d;

  // Captured request
  logic [31:0]       addr_q;
  logic              op_wr_q;
  logic [3:0]        mask_q;
  logic [31:0]       wdata_q;
  logic [WAY_W-1:0]  way_q;

  // Fill progress: issue side and receive side advance independently
  logic [WORD_W-1:0] issue_idx_q;
  logic [WORD_W-1:0] recv_idx_q;
  logic              issue_done_q;

  // Cache storage
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [31:0]       data_q  [SETS][WAYS][WORDS];

  logic [31:0]       hit_cnt_q, miss_cnt_q;

  // Lookup
  logic [31:0]         cur_addr;
  logic [TAG_W-1:0]    cur_tag;
  logic [SET_BITS-1:0] cur_set;
  logic [WORD_W-1:0]   cur_word;
  logic [WAYS-1:0]     cur_valid;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic                inv_found;
  logic [WAY_W-1:0]    inv_way;
  logic [WAY_W-1:0]    victim;
  logic [31:0]         hit_word, line_word, req_bm, line_bm, merged;

  // Control strobes from the FSM
  logic do_flush, do_capture, do_fill_start, do_hit, do_miss;
  logic issue_acc, fill_we, fill_last, write_commit;

  function automatic logic [31:0] byte_mask(input logic [3:0] m);
    logic [31:0] bm;
    for (int i = 0; i < 4; i++) bm[8*i +: 8] = {8{m[i]}};
    return bm;
  endfunction

  // In IDLE the live request is looked up; otherwise the captured one
  always_comb cur_addr = (state_q == IDLE) ? i_req_addr : addr_q;

  assign cur_tag   = cur_addr[31:TAG_LO];
  assign cur_set   = cur_addr[TAG_LO-1:OFFSET_BITS];
  assign cur_word  = cur_addr[OFFSET_BITS-1:2];
  assign cur_valid = valid_q[cur_set];

  // Tag match, plus victim choice: lowest invalid way, else round-robin pointer
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (cur_valid[WAY_W'(w)] && (tag_q[cur_set][w] == cur_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!cur_valid[WAY_W'(w)]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim = inv_found ? inv_way : rr_q[cur_set];
  end

  assign hit_word  = data_q[cur_set][hit_way][cur_word];
  assign line_word = data_q[cur_set][way_q][cur_word];
  assign req_bm    = byte_mask(i_req_mask);
  assign line_bm   = byte_mask(mask_q);
  assign merged    = (line_word & ~line_bm) | (wdata_q & line_bm);

  // Next state, memory/CPU handshake outputs and datapath strobes
  always_comb begin
    state_d       = state_q;
    o_busy        = 1'b0;
    o_res_rdata   = '0;
    o_mem_ren     = 1'b0;
    o_mem_wen     = 1'b0;
    o_mem_addr    = '0;
    o_mem_wdata   = '0;
    do_flush      = 1'b0;
    do_capture    = 1'b0;
    do_fill_start = 1'b0;
    do_hit        = 1'b0;
    do_miss       = 1'b0;
    issue_acc     = 1'b0;
    fill_we       = 1'b0;
    fill_last     = 1'b0;
    write_commit  = 1'b0;
    if (!i_rst) begin
      case (state_q)
        IDLE: begin
          if (i_flush) begin
            // Flush wins over any request; the CPU sees a stall and retries
            o_busy   = 1'b1;
            do_flush = 1'b1;
          end else if (i_req_ren || i_req_wen) begin
            if (hit) begin
              do_hit = 1'b1;
              if (i_req_wen) begin
                o_busy     = 1'b1;
                do_capture = 1'b1;
                state_d    = WRITE;
              end else begin
                o_res_rdata = hit_word & req_bm;
              end
            end else begin
              do_miss       = 1'b1;
              o_busy        = 1'b1;
              do_capture    = 1'b1;
              do_fill_start = 1'b1;
              state_d       = FILL;
            end
          end
        end
        FILL: begin
          o_busy = 1'b1;
          if (!issue_done_q) begin
            o_mem_addr = {addr_q[31:OFFSET_BITS], issue_idx_q, 2'b00};
            o_mem_ren  = i_mem_ready;
            issue_acc  = i_mem_ready;
          end
          if (i_mem_valid) begin
            fill_we = 1'b1;
            if (recv_idx_q == WORD_W'(WORDS - 1)) begin
              fill_last = 1'b1;
              state_d   = op_wr_q ? WRITE : DONE;
            end
          end
        end
        WRITE: begin
          if (i_mem_ready) begin
            o_mem_wen    = 1'b1;
            o_mem_addr   = addr_q;
            o_mem_wdata  = merged;
            write_commit = 1'b1;
            state_d      = IDLE;
          end else begin
            o_busy = 1'b1;
          end
        end
        DONE: begin
          o_res_rdata = line_word & line_bm;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, request capture, valid bits, round-robin pointers and counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      op_wr_q      <= 1'b0;
      mask_q       <= '0;
      wdata_q      <= '0;
      way_q        <= '0;
      issue_idx_q  <= '0;
      recv_idx_q   <= '0;
      issue_done_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q <= state_d;
      if (do_flush) begin
        for (int s = 0; s < int'(SETS); s++) begin
          valid_q[s] <= '0;
          rr_q[s]    <= '0;
        end
      end
      if (do_capture) begin
        addr_q       <= i_req_addr;
        op_wr_q      <= i_req_wen;
        mask_q       <= i_req_mask;
        wdata_q      <= i_req_wdata;
        way_q        <= hit ? hit_way : victim;
        issue_idx_q  <= '0;
        recv_idx_q   <= '0;
        issue_done_q <= 1'b0;
      end
      // Line stays invalid until its last word lands
      if (do_fill_start) valid_q[cur_set][victim] <= 1'b0;
      if (issue_acc) begin
        issue_idx_q <= issue_idx_q + 1'b1;
        if (issue_idx_q == WORD_W'(WORDS - 1)) issue_done_q <= 1'b1;
      end
      if (fill_we) recv_idx_q <= recv_idx_q + 1'b1;
      if (fill_last) begin
        valid_q[cur_set][way_q] <= 1'b1;
        rr_q[cur_set]           <= (WAYS > 1) ? rr_q[cur_set] + 1'b1 : '0;
      end
      if (do_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (do_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them
  always_ff @(posedge i_clk) begin
    if (do_fill_start) tag_q[cur_set][victim] <= cur_tag;
    if (fill_we)       data_q[cur_set][way_q][recv_idx_q] <= i_mem_rdata;
    if (write_commit)  data_q[cur_set][way_q][cur_word] <= merged;
  end

  assign o_hit_count  = hit_cnt_q;
  assign o_miss_count = miss_cnt_q;

endmodule

// File: tb/tb_param_cache.sv
// tb_param_cache: directed bench for param_cache. Instance 0 uses the default
// geometry (16-byte lines, 32 sets, 2 ways); instance 1 uses 32-byte lines,
// 8 sets, 4 ways. A shared memory model returns word = address, two cycles
// after each accepted read, in order.
module tb_param_cache;

  bit   clk = 1'b0;
  logic rst;

  logic        mem_ready [2];
  logic        mem_ren   [2];
  logic        mem_wen   [2];
  logic        mem_valid [2] = '{1'b0, 1'b0};
  logic        busy      [2];
  logic        req_ren   [2];
  logic        req_wen   [2];
  logic        flush     [2];
  logic [3:0]  req_mask  [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2] = '{32'd0, 32'd0};
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] res_rdata [2];
  logic [31:0] hit_cnt   [2];
  logic [31:0] miss_cnt  [2];

  // Memory model state
  logic        v1 [2] = '{1'b0, 1'b0};
  logic [31:0] a1 [2] = '{32'd0, 32'd0};
  int unsigned rd_n   [2] = '{0, 0};
  int unsigned wr_n   [2] = '{0, 0};
  int unsigned both_n [2] = '{0, 0};
  logic [31:0] rd_log [2][256];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  param_cache u_dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_mem_ready(mem_ready[0]), .o_mem_addr(mem_addr[0]), .o_mem_ren(mem_ren[0]),
    .o_mem_wen(mem_wen[0]), .o_mem_wdata(mem_wdata[0]),
    .i_mem_rdata(mem_rdata[0]), .i_mem_valid(mem_valid[0]),
    .o_busy(busy[0]), .i_req_addr(req_addr[0]), .i_req_ren(req_ren[0]),
    .i_req_wen(req_wen[0]), .i_req_mask(req_mask[0]), .i_req_wdata(req_wdata[0]),
    .o_res_rdata(res_rdata[0]), .i_flush(flush[0]),
    .o_hit_count(hit_cnt[0]), .o_miss_count(miss_cnt[0])
  );

  param_cache #(.OFFSET_BITS(5), .SET_BITS(3), .WAYS(4)) u_dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_mem_ready(mem_ready[1]), .o_mem_addr(mem_addr[1]), .o_mem_ren(mem_ren[1]),
    .o_mem_wen(mem_wen[1]), .o_mem_wdata(mem_wdata[1]),
    .i_mem_rdata(mem_rdata[1]), .i_mem_valid(mem_valid[1]),
    .o_busy(busy[1]), .i_req_addr(req_addr[1]), .i_req_ren(req_ren[1]),
    .i_req_wen(req_wen[1]), .i_req_mask(req_mask[1]), .i_req_wdata(req_wdata[1]),
    .o_res_rdata(res_rdata[1]), .o_hit_count(hit_cnt[1]),
    .i_flush(flush[1]), .o_miss_count(miss_cnt[1])
  );

  // Memory: word = byte address, two-cycle read latency, in-order returns
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      v1[d]        <= mem_ren[d] && mem_ready[d];
      a1[d]        <= mem_addr[d];
      mem_valid[d] <= v1[d];
      mem_rdata[d] <= a1[d];
      if (mem_ren[d] && mem_ready[d]) begin
        rd_log[d][rd_n[d] % 256] <= mem_addr[d];
        rd_n[d] <= rd_n[d] + 1;
      end
      if (mem_wen[d] && mem_ready[d]) wr_n[d] <= wr_n[d] + 1;
      if (mem_ren[d] && mem_wen[d]) both_n[d] <= both_n[d] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic start_req(input int d, input logic [31:0] a, input logic [3:0] m,
                           input logic wr, input logic [31:0] wd);
    @(negedge clk);
    req_addr[d]  = a;
    req_mask[d]  = m;
    req_ren[d]   = !wr;
    req_wen[d]   = wr;
    req_wdata[d] = wd;
  endtask

  // Waits for the completing cycle, samples it, then releases the request
  task automatic finish_req(input int d, output logic [31:0] rdata, output int cycles,
                            output logic wen_o, output logic [31:0] waddr,
                            output logic [31:0] wdata_o);
    cycles = 0;
    #1;
    while (busy[d] === 1'b1 && cycles < 300) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    if (cycles >= 300) chk("timeout_busy", {31'd0, busy[d]}, 32'd0);
    rdata   = res_rdata[d];
    wen_o   = mem_wen[d];
    waddr   = mem_addr[d];
    wdata_o = mem_wdata[d];
    @(posedge clk);
    #1;
    req_ren[d] = 1'b0;
    req_wen[d] = 1'b0;
  endtask

  task automatic rd_chk(input int d, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] exp, input logic exp_hit, input string tag);
    logic [31:0] rd, wa, wd;
    logic we;
    int cyc;
    start_req(d, a, m, 1'b0, 32'd0);
    finish_req(d, rd, cyc, we, wa, wd);
    chk({tag, "_data"}, rd, exp);
    chk({tag, "_hit"}, {31'd0, cyc == 0}, {31'd0, exp_hit});
  endtask

  task automatic wr_chk(input int d, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] wdata, input logic [31:0] exp_mem, input string tag);
    logic [31:0] rd, wa, wd;
    logic we;
    int cyc;
    int unsigned n0;
    n0 = wr_n[d];
    start_req(d, a, m, 1'b1, wdata);
    finish_req(d, rd, cyc, we, wa, wd);
    chk({tag, "_wen"}, {31'd0, we}, 32'd1);
    chk({tag, "_addr"}, wa, a);
    chk({tag, "_wdata"}, wd, exp_mem);
    chk({tag, "_rdata0"}, rd, 32'd0);
    chk({tag, "_nwr"}, wr_n[d] - n0, 32'd1);
  endtask

  task automatic cnt_chk(input int d, input logic [31:0] h, input logic [31:0] m, input string tag);
    chk({tag, "_hits"}, hit_cnt[d], h);
    chk({tag, "_miss"}, miss_cnt[d], m);
  endtask

  task automatic fill_log_chk(input int d, input int unsigned n0, input logic [31:0] base,
                              input int words, input string tag);
    chk({tag, "_nrd"}, rd_n[d] - n0, 32'(words));
    for (int k = 0; k < words; k++)
      chk($sformatf("%s_rd%0d", tag, k), rd_log[d][(n0 + 32'(k)) % 256], base + 32'(4 * k));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mem_ready[d] = 1'b1;
      req_ren[d]   = 1'b0;
      req_wen[d]   = 1'b0;
      flush[d]     = 1'b0;
      req_mask[d]  = 4'h0;
      req_addr[d]  = 32'd0;
      req_wdata[d] = 32'd0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_busy", d), {31'd0, busy[d]}, 32'd0);
      chk($sformatf("rst%0d_rdata", d), res_rdata[d], 32'd0);
      chk($sformatf("rst%0d_maddr", d), mem_addr[d], 32'd0);
      chk($sformatf("rst%0d_renwen", d), {30'd0, mem_ren[d], mem_wen[d]}, 32'd0);
      cnt_chk(d, 32'd0, 32'd0, $sformatf("rst%0d", d));
    end

    // ---- instance 0: 16-byte lines, 32 sets, 2 ways ----
    n0 = rd_n[0];
    rd_chk(0, 32'h104, 4'hF, 32'h104, 1'b0, "a_cold");
    fill_log_chk(0, n0, 32'h100, 4, "a_cold");
    rd_chk(0, 32'h108, 4'hF, 32'h108, 1'b1, "a_rehit");
    cnt_chk(0, 32'd1, 32'd1, "a_cold");
    rd_chk(0, 32'h10C, 4'b0101, 32'h0000_000C, 1'b1, "a_mask");

    wr_chk(0, 32'h104, 4'b0010, 32'h0000_AB00, 32'h0000_AB04, "a_whit");
    rd_chk(0, 32'h104, 4'hF, 32'h0000_AB04, 1'b1, "a_wback");
    cnt_chk(0, 32'd4, 32'd1, "a_whit");

    // Same set (16): third fill evicts way 0 (line 0x100)
    rd_chk(0, 32'h300, 4'hF, 32'h300, 1'b0, "a_f300");
    rd_chk(0, 32'h500, 4'hF, 32'h500, 1'b0, "a_f500");
    rd_chk(0, 32'h300, 4'hF, 32'h300, 1'b1, "a_h300");
    rd_chk(0, 32'h100, 4'hF, 32'h100, 1'b0, "a_ev100");
    cnt_chk(0, 32'd5, 32'd4, "a_evict");

    // Write miss: fill then merge
    n0 = rd_n[0];
    wr_chk(0, 32'h208, 4'b1000, 32'h5500_0000, 32'h5500_0208, "a_wmiss");
    fill_log_chk(0, n0, 32'h200, 4, "a_wmiss");
    rd_chk(0, 32'h208, 4'hF, 32'h5500_0208, 1'b1, "a_wmback");

    // Memory not ready for 5 fill cycles
    begin
      logic [31:0] rd, wa, wd;
      logic we;
      int cyc;
      n0 = rd_n[0];
      mem_ready[0] = 1'b0;
      start_req(0, 32'h408, 4'hF, 1'b0, 32'd0);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        #1;
        chk($sformatf("a_stall%0d_addr", i), mem_addr[0], 32'h400);
        chk($sformatf("a_stall%0d_ren", i), {31'd0, mem_ren[0]}, 32'd0);
        chk($sformatf("a_stall%0d_busy", i), {31'd0, busy[0]}, 32'd1);
      end
      mem_ready[0] = 1'b1;
      finish_req(0, rd, cyc, we, wa, wd);
      chk("a_stall_data", rd, 32'h408);
      fill_log_chk(0, n0, 32'h400, 4, "a_stall");
    end
    cnt_chk(0, 32'd6, 32'd6, "a_stall");

    // Flush while a request is present: flush wins, nothing counted
    start_req(0, 32'h104, 4'hF, 1'b0, 32'd0);
    flush[0] = 1'b1;
    #1;
    chk("a_flush_busy", {31'd0, busy[0]}, 32'd1);
    chk("a_flush_rdata", res_rdata[0], 32'd0);
    @(posedge clk);
    #1;
    flush[0]   = 1'b0;
    req_ren[0] = 1'b0;
    cnt_chk(0, 32'd6, 32'd6, "a_flush");
    rd_chk(0, 32'h104, 4'hF, 32'h104, 1'b0, "a_postflush");
    cnt_chk(0, 32'd6, 32'd7, "a_postflush");

    // Reset in the middle of a fill
    start_req(0, 32'h600, 4'hF, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    rst        = 1'b1;
    req_ren[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("a_rstfill_busy", {31'd0, busy[0]}, 32'd0);
    chk("a_rstfill_ren", {31'd0, mem_ren[0]}, 32'd0);
    cnt_chk(0, 32'd0, 32'd0, "a_rstfill");
    repeat (4) @(negedge clk);
    rd_chk(0, 32'h600, 4'hF, 32'h600, 1'b0, "a_refill600");
    rd_chk(0, 32'h104, 4'hF, 32'h104, 1'b0, "a_refill104");
    cnt_chk(0, 32'd0, 32'd2, "a_refill");

    // ---- instance 1: 32-byte lines, 8 sets, 4 ways ----
    n0 = rd_n[1];
    rd_chk(1, 32'h104, 4'hF, 32'h104, 1'b0, "b_cold");
    fill_log_chk(1, n0, 32'h100, 8, "b_cold");
    rd_chk(1, 32'h108, 4'hF, 32'h108, 1'b1, "b_rehit");
    cnt_chk(1, 32'd1, 32'd1, "b_cold");

    // Set 0 holds four lines before anything is evicted
    rd_chk(1, 32'h300, 4'hF, 32'h300, 1'b0, "b_f300");
    rd_chk(1, 32'h500, 4'hF, 32'h500, 1'b0, "b_f500");
    rd_chk(1, 32'h700, 4'hF, 32'h700, 1'b0, "b_f700");
    rd_chk(1, 32'h100, 4'hF, 32'h100, 1'b1, "b_h100");
    rd_chk(1, 32'h900, 4'hF, 32'h900, 1'b0, "b_f900");
    rd_chk(1, 32'h300, 4'hF, 32'h300, 1'b1, "b_h300");
    rd_chk(1, 32'h704, 4'b0011, 32'h0000_0704, 1'b1, "b_h704");
    rd_chk(1, 32'h100, 4'hF, 32'h100, 1'b0, "b_ev100");
    rd_chk(1, 32'h500, 4'hF, 32'h500, 1'b1, "b_h500");
    cnt_chk(1, 32'd5, 32'd6, "b_evict");

    chk("a_ren_wen_overlap", both_n[0], 32'd0);
    chk("b_ren_wen_overlap", both_n[1], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
